// File: rtl/gaussian_stream_ctrl_if.sv
// Stream and filter-control bundle for the Gaussian frame sequencer.
// master: the sequencer. slave: the environment (upstream, downstream and filter).
interface gaussian_stream_ctrl_if;
  // upstream pixel stream
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  // downstream filtered stream
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  // filter datapath control
  logic [7:0] filt_din;
  logic       filt_ce;
  logic       filt_sclr;
  logic [7:0] filt_dout;

  modport master (
    input  in_data, in_valid, out_ready, filt_dout,
    output in_ready, out_data, out_valid, out_sof, out_eol, out_eof,
           filt_din, filt_ce, filt_sclr
  );

  modport slave (
    output in_data, in_valid, out_ready, filt_dout,
    input  in_ready, out_data, out_valid, out_sof, out_eol, out_eof,
           filt_din, filt_ce, filt_sclr
  );
endinterface

// File: rtl/gaussian_stream_ctrl.sv
// Frame sequencer for the two-stage 5-tap Gaussian filter. Feeds the frame
// into the filter, hides the priming outputs, flushes with zero pixels and
// emits exactly WIDTH*HEIGHT filtered pixels with sof/eol/eof markers.
module gaussian_stream_ctrl #(
  parameter int WIDTH      = 400,
  parameter int HEIGHT     = 300,
  parameter int CENTER_DLY = 802,
  parameter int CNT_W      = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic frame_done,
  gaussian_stream_ctrl_if.master bus
);

  localparam int TOTAL_I = WIDTH * HEIGHT;
  localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(TOTAL_I);
  localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(TOTAL_I - 1);
  localparam logic [CNT_W-1:0] CD        = CNT_W'(CENTER_DLY);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL_I + CENTER_DLY - 1);
  localparam logic [CNT_W-1:0] LAST_COL  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    RUN   = 3'd3,
    FLUSH = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] beat_cnt_reg, in_cnt_reg, col_reg, row_reg;
  logic [CNT_W-1:0] beat_cnt_inc, col_adv, row_adv;
  logic [7:0]       out_data_reg;
  logic             out_valid_reg, out_sof_reg, out_eol_reg, out_eof_reg;
  logic             filt_sclr_reg;
  logic             in_ready, filt_ce, abort_take, accept;
  logic [7:0]       filt_din;

  assign abort_take   = abort && (state_reg != IDLE);
  assign accept       = out_valid_reg && bus.out_ready;
  assign beat_cnt_inc = beat_cnt_reg + 1'b1;

  // Handshake and filter enable: a beat is only issued when the output
  // register is free or being emptied, so a pending pixel is never overwritten.
  always_comb begin
    in_ready = 1'b0;
    filt_ce  = 1'b0;
    filt_din = 8'd0;
    case (state_reg)
      FILL, RUN: begin
        in_ready = (in_cnt_reg < TOTAL) && (!out_valid_reg || bus.out_ready) && !abort;
        filt_ce  = bus.in_valid && in_ready;
        filt_din = bus.in_data;
      end
      FLUSH: begin
        filt_ce = (!out_valid_reg || bus.out_ready) && !abort;
      end
      default: ;
    endcase
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start) state_next = CLEAR;
      CLEAR: state_next = FILL;
      FILL, RUN: begin
        if (filt_ce) begin
          if (in_cnt_reg == LAST_IN)    state_next = FLUSH;
          else if (beat_cnt_inc >= CD)  state_next = RUN;
          else                          state_next = FILL;
        end
      end
      // Leave only on the final flush beat, never on a stalled cycle.
      FLUSH: if (filt_ce && (beat_cnt_reg == LAST_BEAT)) state_next = DRAIN;
      DRAIN: if (!out_valid_reg || bus.out_ready) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_take) state_next = IDLE;
  end

  // Output position after any acceptance on this edge; markers for a newly
  // loaded pixel must reflect the slot it will occupy.
  always_comb begin
    col_adv = col_reg;
    row_adv = row_reg;
    if (accept) begin
      if (col_reg == LAST_COL) begin
        col_adv = '0;
        row_adv = row_reg + 1'b1;
      end else begin
        col_adv = col_reg + 1'b1;
      end
    end
  end

  // State register and registered filter clear (high during CLEAR and
  // for one cycle after an abort).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      filt_sclr_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      filt_sclr_reg <= abort_take || (state_next == CLEAR);
    end
  end

  // Beat, input and output position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_reg <= '0;
      in_cnt_reg   <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
    end else if (abort_take || (state_reg == CLEAR)) begin
      beat_cnt_reg <= '0;
      in_cnt_reg   <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
    end else begin
      if (filt_ce) beat_cnt_reg <= beat_cnt_inc;
      if (in_ready && bus.in_valid) in_cnt_reg <= in_cnt_reg + 1'b1;
      col_reg <= col_adv;
      row_reg <= row_adv;
    end
  end

  // Output register: capture the filter result once the centred tap is
  // valid, otherwise drop valid when downstream takes the pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= 8'd0;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      out_eol_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
    end else if (abort_take) begin
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      out_eol_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
    end else if (filt_ce && (beat_cnt_reg >= CD)) begin
      out_data_reg  <= bus.filt_dout;
      out_valid_reg <= 1'b1;
      out_sof_reg   <= (col_adv == '0) && (row_adv == '0);
      out_eol_reg   <= (col_adv == LAST_COL);
      out_eof_reg   <= (col_adv == LAST_COL) && (row_adv == LAST_ROW);
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign busy          = (state_reg != IDLE);
  assign frame_done    = (state_reg == DONE);
  assign bus.in_ready  = in_ready;
  assign bus.filt_ce   = filt_ce;
  assign bus.filt_din  = filt_din;
  assign bus.filt_sclr = filt_sclr_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sof   = out_sof_reg;
  assign bus.out_eol   = out_eol_reg;
  assign bus.out_eof   = out_eof_reg;

endmodule

// File: doc/gaussian_stream_ctrl.md
Name: gaussian_stream_ctrl

Overview:
- Frame-level sequencer for the two-stage 5-tap Gaussian filter datapath (horizontal taps plus vertical line buffers).
- Accepts an 8-bit pixel stream with valid/ready and drives the filter's clock enable, input mux and synchronous clear.
- Suppresses outputs while the line buffers prime, then flushes the pipeline with zero pixels at end of frame.
- Emits exactly WIDTH*HEIGHT filtered pixels per frame with sof/eol/eof markers and downstream backpressure.

Parameters:
- WIDTH, 400, pixels per row (equal to the line-buffer length).
- HEIGHT, 300, rows per frame.
- CENTER_DLY, 802, filter beats from input pixel to its centred output (2*WIDTH+2).
- CNT_W, 18, beat/pixel counter width; must hold WIDTH*HEIGHT+CENTER_DLY.

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise
- abort  in  1  synchronous; abandons the current frame
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last output is accepted
- in_data  in  8  upstream pixel
- in_valid  in  1  upstream valid
- in_ready  out  1  upstream ready
- out_data  out  8  filtered pixel (registered)
- out_valid  out  1  downstream valid
- out_ready  in  1  downstream ready
- out_sof  out  1  qualifies out_data: first pixel of frame
- out_eol  out  1  qualifies out_data: last pixel of row
- out_eof  out  1  qualifies out_data: last pixel of frame
- filt_din  out  8  to filter din
- filt_ce  out  1  to filter Clk_en; one beat per high cycle
- filt_sclr  out  1  to filter Reset and line-buffer Sclr
- filt_dout  in  8  from filter dout (combinational on the current beat)

Behaviour:
- Reset (async) clears everything: state=IDLE, out_valid=0, out_data=0, markers=0, counters=0, frame_done=0, filt_sclr=0, busy=0. Control outputs in_ready and filt_ce are combinational and are 0 while in IDLE.
- States:
  - IDLE: on start go to CLEAR.
  - CLEAR: one cycle. filt_sclr=1, filt_ce=0, in_ready=0; beat_cnt, in_cnt, col and row are zeroed. Next state is FILL.
  - FILL/RUN:
    - in_ready = (in_cnt<WIDTH*HEIGHT) & (~out_valid | out_ready).
    - filt_ce = in_valid & in_ready; filt_din = in_data.
    - Every beat increments in_cnt.
    - State is FILL while beat_cnt<CENTER_DLY, else RUN; the label is informational only.
    - When in_cnt reaches WIDTH*HEIGHT, go to FLUSH.
  - FLUSH:
    - in_ready=0; filt_din=0; filt_ce = (~out_valid | out_ready).
    - When beat_cnt reaches WIDTH*HEIGHT+CENTER_DLY, go to DRAIN.
  - DRAIN: filt_ce=0. Once out_valid=0, or out_valid&out_ready, go to DONE.
  - DONE: frame_done=1 for one cycle, then IDLE.
- Beat rule:
  - Every filt_ce cycle increments beat_cnt.
  - If beat_cnt (pre-increment) >= CENTER_DLY, the same edge loads out_data<=filt_dout, out_valid<=1, and the markers for the current col/row.
  - Otherwise out_valid is cleared on out_ready.
  - Pending output is never overwritten; filt_ce gating guarantees this.
- Output counters:
  - col and row advance on each out_valid&out_ready.
  - col wraps at WIDTH-1 → 0 and increments row.
  - out_sof = (col==0 & row==0); out_eol = (col==WIDTH-1); out_eof = out_eol & (row==HEIGHT-1).
- Latency: the first output is valid the cycle after beat CENTER_DLY+1. With no stalls, the first out_valid rises CENTER_DLY+1 cycles after the first accepted pixel.
- Throughput: one pixel per cycle when in_valid and out_ready are held high.
- abort: in any non-IDLE state, the next state is IDLE and filt_sclr pulses for 1 cycle. out_valid, markers and counters are cleared, and no frame_done is generated. abort has priority over start and all transitions.
- start while busy: ignored.
- Reset asserted mid-frame: immediate return to reset values. The filter contents are stale until the next CLEAR.
- Simultaneous stall plus last beat: the FLUSH→DRAIN transition occurs only on the final beat, never on a stalled cycle.

Test Plan:
- WIDTH=8, HEIGHT=4, CENTER_DLY=18; start, then 32 pixels with in_valid and out_ready held high:
  - 32 outputs; first out_valid 19 cycles after the first accepted pixel.
  - out_sof on output 0; out_eol on outputs 7, 15, 23, 31; out_eof on output 31.
  - frame_done exactly once, after output 31.
- Same frame with out_ready toggling 1-0-1-0: no output lost or duplicated; out_data holds while out_valid&~out_ready; filt_ce=0 on those cycles.
- Constant input 100, kernel coefficients summing to 256 under the filter's integer division: interior outputs equal the constant checked against a reference model; border outputs checked for zero-padding values.
- abort asserted at input pixel 20: next cycle busy=0 and out_valid=0; one filt_sclr pulse; no frame_done. A following start and full frame gives a clean output count of 32.
- Async Reset asserted mid-FLUSH: all outputs at reset values immediately, with no clock edge required.
- start pulsed while busy, and in_valid held with no start: frame unaffected; no beats occur while IDLE.
